// File: rtl/aes_enc_core.sv
// AES-128 encryption core, ROUNDS_PER_CYCLE rounds per clock with on-the-fly key expansion.
// out_valid rises 10/ROUNDS_PER_CYCLE edges after accept; result held until out_ready, one block in flight.
module aes_enc_core #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plain_text,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] cipher_text,
    output logic         busy
);

    localparam int R = ROUNDS_PER_CYCLE;

    generate
        if (R != 1 && R != 2 && R != 5 && R != 10) begin : g_bad_rounds
            $error("aes_enc_core: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
        end
    endgenerate

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        return {sub_word(s[127:96]), sub_word(s[95:64]), sub_word(s[63:32]), sub_word(s[31:0])};
    endfunction

    // Byte b = row + 4*col sits at [127-8b -: 8]; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + r) % 4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        return {mix_col(s[127:96]), mix_col(s[95:64]), mix_col(s[63:32]), mix_col(s[31:0])};
    endfunction

    function automatic logic [127:0] key_expand(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = sub_word({rk[23:0], rk[31:24]}) ^ {rc, 24'h0};
        w0 = rk[127:96] ^ t;
        w1 = rk[95:64]  ^ w0;
        w2 = rk[63:32]  ^ w1;
        w3 = rk[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    fsm_t         fsm;
    logic [127:0] st_q;
    logic [127:0] rk_q;
    logic [7:0]   rc_q;
    logic [3:0]   round_cnt;
    logic         last_step;

    logic [127:0] st_ch [R+1];
    logic [127:0] rk_ch [R+1];
    logic [7:0]   rc_ch [R+1];

    assign st_ch[0] = st_q;
    assign rk_ch[0] = rk_q;
    assign rc_ch[0] = rc_q;

    // Only the final stage of the final cycle can land on round 10.
    assign last_step = (round_cnt == 4'(11 - R));

    generate
        for (genvar g = 0; g < R; g++) begin : g_round
            logic [127:0] sr;
            logic [127:0] rk_n;
            assign rk_n        = key_expand(rk_ch[g], rc_ch[g]);
            assign rk_ch[g+1]  = rk_n;
            assign rc_ch[g+1]  = xtime(rc_ch[g]);
            assign sr          = shift_rows(sub_bytes(st_ch[g]));
            if (g == R - 1) begin : g_last
                assign st_ch[g+1] = (last_step ? sr : mix_columns(sr)) ^ rk_n;
            end else begin : g_mid
                assign st_ch[g+1] = mix_columns(sr) ^ rk_n;
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm         <= IDLE;
            st_q        <= '0;
            rk_q        <= '0;
            rc_q        <= '0;
            round_cnt   <= '0;
            out_valid   <= 1'b0;
            cipher_text <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        st_q      <= plain_text ^ key;
                        rk_q      <= key;
                        rc_q      <= 8'h01;
                        round_cnt <= 4'd1;
                        fsm       <= RUN;
                    end
                end
                RUN: begin
                    st_q <= st_ch[R];
                    rk_q <= rk_ch[R];
                    rc_q <= rc_ch[R];
                    if (last_step) begin
                        round_cnt   <= 4'd10;
                        out_valid   <= 1'b1;
                        cipher_text <= st_ch[R];
                        fsm         <= DONE;
                    end else begin
                        round_cnt <= round_cnt + 4'(R);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid   <= 1'b0;
                        cipher_text <= '0;
                        round_cnt   <= '0;
                        fsm         <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    assign in_ready = (fsm == IDLE) && !rst;
    assign busy     = (fsm != IDLE);

endmodule

// File: tb/tb_aes_enc_core.sv
// Bench: four cores (1/2/5/10 rounds per cycle) against a byte-level FIPS-197 model.
module tb_aes_enc_core;

    localparam int NL = 4;
    localparam int RV [NL] = '{1, 2, 5, 10};

    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

    logic clk = 1'b0;
    logic rst;
    logic [NL-1:0]        in_valid_a;
    logic [NL-1:0]        out_ready_a;
    logic [NL-1:0][127:0] pt_a;
    logic [NL-1:0][127:0] key_a;
    wire  [NL-1:0]        in_ready_w;
    wire  [NL-1:0]        out_valid_w;
    wire  [NL-1:0]        busy_w;
    wire  [NL-1:0][127:0] ct_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < NL; g++) begin : g_dut
            aes_enc_core #(.ROUNDS_PER_CYCLE(RV[g])) u_dut (
                .clk         (clk),
                .rst         (rst),
                .in_valid    (in_valid_a[g]),
                .in_ready    (in_ready_w[g]),
                .plain_text  (pt_a[g]),
                .key         (key_a[g]),
                .out_valid   (out_valid_w[g]),
                .out_ready   (out_ready_a[g]),
                .cipher_text (ct_w[g]),
                .busy        (busy_w[g])
            );
        end
    endgenerate

    task automatic chk(input string nm, input int lane, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s lane %0d: got %h expected %h", nm, lane, act, exp);
        end
    endtask

    // ---------------- reference model: plain GF(2^8) arithmetic ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_m(input logic [7:0] x);
        logic [7:0] p = x;
        logic [7:0] inv = 8'h01;
        logic [7:0] s;
        for (int k = 1; k < 8; k++) begin   // x^254 = x^-1 (0 maps to 0)
            p   = gmul(p, p);
            inv = gmul(inv, p);
        end
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [127:0] aes_model(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] w [176];
        logic [7:0] tmp [4];
        logic [7:0] rc = 8'h01;
        logic [127:0] res;
        for (int b = 0; b < 16; b++) begin
            w[b] = key[127 - 8*b -: 8];
            s[b] = pt[127 - 8*b -: 8];
        end
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[4*(i-1) + j];
            if (i % 4 == 0) begin
                tmp = '{sbox_m(w[4*i-3]) ^ rc, sbox_m(w[4*i-2]), sbox_m(w[4*i-1]), sbox_m(w[4*i-4])};
                rc  = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[4*i + j] = w[4*(i-4) + j] ^ tmp[j];
        end
        for (int b = 0; b < 16; b++) s[b] = s[b] ^ w[b];
        for (int r = 1; r <= 10; r++) begin
            for (int b = 0; b < 16; b++) s[b] = sbox_m(s[b]);
            for (int c = 0; c < 4; c++)
                for (int rw = 0; rw < 4; rw++) t[rw + 4*c] = s[rw + 4*((c + rw) % 4)];
            for (int c = 0; c < 4; c++) begin
                if (r < 10) begin
                    s[4*c]   = gmul(t[4*c], 2) ^ gmul(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 2) ^ gmul(t[4*c+2], 3) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 2) ^ gmul(t[4*c+3], 3);
                    s[4*c+3] = gmul(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 2);
                end else begin
                    for (int rw = 0; rw < 4; rw++) s[4*c + rw] = t[4*c + rw];
                end
            end
            for (int b = 0; b < 16; b++) s[b] = s[b] ^ w[16*r + b];
        end
        res = '0;
        for (int b = 0; b < 16; b++) res[127 - 8*b -: 8] = s[b];
        return res;
    endfunction

    // ---------------- per-lane transaction model + compare ----------------
    bit           m_fly  [NL];   // a block has been accepted and not yet handed off
    int           m_left [NL];   // edges still to go before out_valid must be high
    logic [127:0] m_exp  [NL];
    int           m_done [NL];

    initial begin
        for (int l = 0; l < NL; l++) begin
            m_fly[l]  = 1'b0;
            m_left[l] = 0;
            m_exp[l]  = '0;
            m_done[l] = 0;
        end
    end

    always @(negedge clk) begin
        for (int l = 0; l < NL; l++) begin
            if (rst) begin
                chk("rst_out_valid", l, 128'(out_valid_w[l]), 128'(0));
                chk("rst_in_ready", l, 128'(in_ready_w[l]), 128'(0));
                chk("rst_busy", l, 128'(busy_w[l]), 128'(0));
                chk("rst_cipher_text", l, ct_w[l], 128'(0));
                m_fly[l] = 1'b0;
            end else begin
                logic exp_ov;
                exp_ov = m_fly[l] && (m_left[l] == 0);
                chk("out_valid", l, 128'(out_valid_w[l]), 128'(exp_ov));
                chk("in_ready", l, 128'(in_ready_w[l]), 128'(!m_fly[l]));
                chk("busy", l, 128'(busy_w[l]), 128'(m_fly[l]));
                chk("cipher_text", l, ct_w[l], exp_ov ? m_exp[l] : 128'(0));
                // Inputs are stable until the next edge; predict what it does.
                if (!m_fly[l]) begin
                    if (in_valid_a[l]) begin
                        m_fly[l]  = 1'b1;
                        m_left[l] = 10 / RV[l];
                        m_exp[l]  = aes_model(pt_a[l], key_a[l]);
                    end
                end else if (m_left[l] > 0) begin
                    m_left[l]--;
                end else if (out_ready_a[l]) begin
                    m_fly[l] = 1'b0;
                    m_done[l]++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int           lat      [NL];
    logic [127:0] first_ct [NL];
    int           base_done [NL];
    bit           all_done;

    initial begin
        rst         = 1'b1;
        in_valid_a  = '0;
        out_ready_a = '0;
        pt_a        = '0;
        key_a       = '0;

        chk("model_vec_c", 0, aes_model(PT_C, KEY_C), CT_C);
        chk("model_vec_b", 0, aes_model(PT_B, KEY_B), CT_B);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Known vectors on every lane, long stall, junk inputs during RUN on lane 0.
        for (int l = 0; l < NL; l++) begin
            in_valid_a[l] = 1'b1;
            pt_a[l]       = (l == 0) ? PT_C : PT_B;
            key_a[l]      = (l == 0) ? KEY_C : KEY_B;
            lat[l]        = 0;
        end
        @(posedge clk);
        #1;
        in_valid_a    = '0;
        in_valid_a[0] = 1'b1;
        pt_a[0]       = {$urandom, $urandom, $urandom, $urandom};
        key_a[0]      = {$urandom, $urandom, $urandom, $urandom};
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (cyc == 2) in_valid_a[0] = 1'b0;
            @(posedge clk);
            #1;
            for (int l = 0; l < NL; l++) begin
                if (out_valid_w[l] && lat[l] == 0) begin
                    lat[l]      = cyc;
                    first_ct[l] = ct_w[l];
                end
            end
        end
        for (int l = 0; l < NL; l++) begin
            chk("latency", l, 128'(lat[l]), 128'(10 / RV[l]));
            chk("vector_ct", l, ct_w[l], (l == 0) ? CT_C : CT_B);
            chk("stall_stable_ct", l, ct_w[l], first_ct[l]);
            chk("stall_out_valid", l, 128'(out_valid_w[l]), 128'(1));
        end
        out_ready_a = '1;
        @(posedge clk);
        #1 out_ready_a = '0;
        for (int l = 0; l < NL; l++) begin
            chk("handoff_out_valid", l, 128'(out_valid_w[l]), 128'(0));
            chk("handoff_in_ready", l, 128'(in_ready_w[l]), 128'(1));
            chk("handoff_count", l, 128'(m_done[l]), 128'(1));
        end

        // Abort lane 0 mid-block with reset, then restart immediately after release.
        in_valid_a[0] = 1'b1;
        pt_a[0]       = PT_C;
        key_a[0]      = KEY_C;
        @(posedge clk);
        #1 in_valid_a[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        rst           = 1'b0;
        in_valid_a[0] = 1'b1;
        @(posedge clk);
        #1 in_valid_a[0] = 1'b0;
        lat[0] = 0;
        for (int cyc = 1; cyc <= 20 && lat[0] == 0; cyc++) begin
            @(posedge clk);
            #1;
            if (out_valid_w[0]) lat[0] = cyc;
        end
        chk("restart_latency", 0, 128'(lat[0]), 128'(10));
        chk("restart_ct", 0, ct_w[0], CT_C);
        chk("abort_no_extra_output", 0, 128'(m_done[0]), 128'(1));
        out_ready_a[0] = 1'b1;
        @(posedge clk);
        #1 out_ready_a[0] = 1'b0;

        // Random traffic with random consumer stalls on all lanes.
        for (int l = 0; l < NL; l++) base_done[l] = m_done[l];
        all_done = 1'b0;
        for (int cyc = 0; cyc < 6000 && !all_done; cyc++) begin
            @(posedge clk);
            #1;
            all_done = 1'b1;
            for (int l = 0; l < NL; l++) begin
                in_valid_a[l]  = ($urandom_range(0, 3) != 0);
                out_ready_a[l] = ($urandom_range(0, 2) != 0);
                pt_a[l]        = {$urandom, $urandom, $urandom, $urandom};
                key_a[l]       = {$urandom, $urandom, $urandom, $urandom};
                if (m_done[l] - base_done[l] < 100) all_done = 1'b0;
            end
        end
        in_valid_a  = '0;
        out_ready_a = '1;
        repeat (3) @(posedge clk);
        for (int l = 0; l < NL; l++)
            chk("random_blocks_done", l, 128'(m_done[l] - base_done[l] >= 100), 128'(1));

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_enc_core.md
AES_ENC_CORE -- requirements
Module: aes_enc_core

Interface
REQ-001 Parameter ROUNDS_PER_CYCLE, default 1: AES rounds executed per clock; legal values 1, 2, 5, 10; any other value SHALL fail elaboration.
REQ-002 Reset is asynchronous and active-high; one clock domain, all state on clk rising edge.
REQ-003 clk  input  1  single clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 in_valid  input  1  plain_text/key valid.
REQ-006 in_ready  output  1  core can accept a block.
REQ-007 plain_text  input  128  plaintext, FIPS-197 byte 0 at [127:120].
REQ-008 key  input  128  AES-128 cipher key, same byte order.
REQ-009 out_valid  output  1  cipher_text valid.
REQ-010 out_ready  input  1  consumer accepts cipher_text.
REQ-011 cipher_text  output  128  ciphertext, same byte order.
REQ-012 busy  output  1  high whenever not IDLE.

Function
REQ-013 Block SHALL implement AES-128 encryption per FIPS-197 (10 rounds, final round without MixColumns), reusing the existing SubBytes, ShiftRows, MixColumns, AddRoundKey blocks.
REQ-014 FSM states IDLE, RUN, DONE; IDLE->RUN on accept, RUN->DONE on last round edge, DONE->IDLE on out_valid && out_ready.
REQ-015 in_ready SHALL equal (state == IDLE); accept = in_valid && in_ready.
REQ-016 On accept: state register <= plain_text ^ key, round-key register <= key, rcon register <= 8'h01, round counter <= 1, plain_text/key sampled only on this edge.
REQ-017 In RUN each edge SHALL apply ROUNDS_PER_CYCLE chained rounds combinationally, each round expanding its round key on the fly from the previous one (RotWord, SubWord, rcon XOR) and advancing rcon by xtime (0x80 -> 0x1B).
REQ-018 Round r == 10 SHALL omit MixColumns; only the last unrolled stage of the final cycle can be round 10.
REQ-019 Round counter 4 bits, increments by ROUNDS_PER_CYCLE per RUN edge; SHALL never exceed 10.
REQ-020 Latency: out_valid SHALL rise on the (10/ROUNDS_PER_CYCLE)-th rising edge after the accept edge (10 for R=1, 1 for R=10).
REQ-021 cipher_text SHALL be registered, held stable while out_valid && !out_ready, for any number of stall cycles.
REQ-022 On out_valid && out_ready edge: out_valid <= 0, state -> IDLE; in_ready high the following cycle (no same-cycle re-accept).
REQ-023 in_valid during RUN/DONE SHALL be ignored; inputs changing after accept SHALL not affect the result.
REQ-024 cipher_text SHALL read 0 whenever out_valid is low.

Reset
REQ-025 rst high SHALL immediately force IDLE, in_ready=1 (after release only), out_valid=0, busy=0, cipher_text=0, counter=0, state/round-key/rcon=0.
REQ-026 in_ready SHALL be 0 while rst is high.
REQ-027 rst asserted mid-RUN or in DONE SHALL abort the block with no later out_valid; first edge after release SHALL accept a new block if in_valid.

Verification
REQ-028 R=1, pt 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f -> cipher_text 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 10 edges after accept.
REQ-029 R=2,5,10, pt 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c -> 3925841d02dc09fbdc118597196a0b32 at 5/2/1 edges latency.
REQ-030 out_ready low 7 cycles after out_valid -> cipher_text and out_valid stable all 7 cycles, single handoff, in_ready high next cycle.
REQ-031 Change plain_text/key and pulse in_valid during RUN -> ignored, result equals REQ-028 vector.
REQ-032 rst pulse at round 5 then new REQ-028 block -> no output for aborted block, correct output 10 edges after new accept.
REQ-033 Back-to-back 100 random blocks with random out_ready stalls -> all match a software AES-128 model, in order.
